kmer_query_controller: RTL and testbench
========================================

KMER_QUERY_CONTROLLER -- requirements
Module: kmer_query_controller

Interface
REQ-001 Parameter NUM_KMERS, default 212, meaning k-mers per read to query.
REQ-002 Parameter ROW_AW, default 8, meaning SRAM row address width.
REQ-003 Parameter ROW_W, default 32, meaning SRAM row width in bits; bit index width BIT_W = log2(ROW_W).
REQ-004 Port clk  in  1  system clock, rising edge.
REQ-005 Port reset  in  1  reset, asynchronous, active-low.
REQ-006 Port start_query  in  1  one-cycle pulse that starts a query pass.
REQ-007 Port hash_valid / hash_ready  in / out  1 / 1  handshake with the upstream LFSR hash datapath.
REQ-008 Port hash1, hash2  in  ROW_AW+BIT_W each  hashed address; the upper ROW_AW bits are the row and the lower BIT_W bits are the bit index.
REQ-009 Port A1, A2  out  ROW_AW  SRAM row addresses.
REQ-010 Port CSB1, CSB2, WEB1, WEB2, OEB1, OEB2  out  1  active-low SRAM controls.
REQ-011 Port DOUT1, DOUT2  in  ROW_W  SRAM read data.
REQ-012 Port kmer_valid / kmer_ready  out / in  1 / 1  result handshake.
REQ-013 Port kmer_solid  out  1  asserted when both hashed bits are set.
REQ-014 Port kmer_idx  out  8  index of the current k-mer, 0..NUM_KMERS-1.
REQ-015 Port solid_count  out  8  running count of solid k-mers.
REQ-016 Port query_done  out  1  one-cycle pulse at the end of a pass.

Function
REQ-017 The FSM states and transitions SHALL be exactly:
- IDLE -> WAIT_HASH on start_query.
- WAIT_HASH -> SET_ADDR on hash_valid&&hash_ready.
- SET_ADDR -> READ.
- READ -> CHECK.
- CHECK -> EMIT.
- EMIT -> WAIT_HASH on kmer_ready when kmer_idx<NUM_KMERS-1.
- EMIT -> DONE on kmer_ready when kmer_idx==NUM_KMERS-1.
- DONE -> IDLE.
REQ-018 hash_ready SHALL be 1 only in WAIT_HASH; hash1 and hash2 SHALL be captured on the accepting edge.
REQ-019 In SET_ADDR, A1/A2 SHALL drive the captured rows, with CSB=0 and OEB=0.
REQ-020 In READ, OEB=0 SHALL be held and DOUT1/DOUT2 SHALL be registered at the end of the cycle.
REQ-021 In CHECK, kmer_solid SHALL be registered as DOUT1_reg[bit1] & DOUT2_reg[bit2].
REQ-022 WEB1 and WEB2 SHALL be 1 in every state; this block never writes.
REQ-023 In all states other than SET_ADDR/READ, OEB SHALL be 1 and CSB SHALL be 0.
REQ-024 kmer_valid SHALL be 1 only in EMIT; kmer_solid and kmer_idx SHALL be held stable while kmer_valid=1 and kmer_ready=0.
REQ-025 solid_count SHALL increment by 1 on the EMIT handshake when kmer_solid=1.
REQ-026 kmer_idx SHALL increment by 1 on each EMIT handshake.
REQ-027 kmer_idx and solid_count SHALL clear to 0 on start_query accepted in IDLE.
REQ-028 solid_count SHALL hold its value after DONE until the next start.
REQ-029 query_done SHALL be 1 for exactly the single DONE cycle.
REQ-030 Latency from hash acceptance to kmer_valid SHALL be 4 cycles.
REQ-031 start_query outside IDLE SHALL be ignored.
REQ-032 When hash_valid is low, the FSM SHALL stay in WAIT_HASH indefinitely with no SRAM access.
REQ-033 NUM_KMERS=1 SHALL go from EMIT directly to DONE after the first handshake.

Reset
REQ-034 While reset=0, state SHALL be IDLE, all counters 0, hash_ready=0, kmer_valid=0, kmer_solid=0, query_done=0, A1=A2=0, CSB=0, WEB=1, OEB=1.
REQ-035 Asserting reset mid-pass SHALL abort the pass immediately with no query_done; the next pass requires a new start_query.

Configuration
REQ-036 With KMER_QUERY_STATS_EN defined:
- add output weak_count (8 bits), incremented on each non-solid EMIT handshake;
- add output first_weak_idx (8 bits), holding the kmer_idx of the first non-solid k-mer, 8'hFF if none;
- both SHALL clear on start.
REQ-037 Without KMER_QUERY_STATS_EN, weak_count and first_weak_idx SHALL still exist as ports, tied to 0 and 8'hFF respectively, with no registers.

Structure
REQ-038 The state enum, the default NUM_KMERS, and the SRAM control idle values SHALL live in shared package dna_ec_pkg, shared with the generation controller.
REQ-039 One sub-module, kmer_bit_check, SHALL perform the registered row capture plus the bit-select AND; the FSM and counters SHALL stay in the top module.

Verification
REQ-040 The bench SHALL cover each scenario below:
- Single solid k-mer: NUM_KMERS=1; DOUT1 bit 3 and DOUT2 bit 17 set; hash1={8'h05,5'd3}, hash2={8'h0A,5'd17}. Required: A1=5, A2=10 in SET_ADDR; kmer_solid=1; solid_count=1; query_done pulse.
- Weak k-mer: same as above but DOUT2 bit 17 clear. Required: kmer_solid=0, solid_count=0; with the macro, weak_count=1 and first_weak_idx=0.
- Full pass: 212 k-mers, every 4th solid. Required: solid_count=53, a single query_done, kmer_idx wraps to 0 at the next start.
- Backpressure: kmer_ready held low for 5 cycles in EMIT. Required: kmer_valid, kmer_solid, kmer_idx stable; no hash_ready; no SRAM access.
- Reset mid-pass: reset low at k-mer 100. Required: outputs at reset values, no query_done; a new start gives solid_count counting from 0.
- Stall plus ignored start: hash_valid low for 10 cycles and start_query pulsed while in WAIT_HASH. Required: no state change, WEB=1 and OEB=1 throughout.

Source files
------------

// File: rtl/dna_ec_pkg.sv
// Shared definitions for the DNA error-correction controllers: query FSM states,
// default k-mer count and SRAM control idle levels (all SRAM controls are active-low).
package dna_ec_pkg;

  localparam int unsigned NUM_KMERS_DEFAULT = 212;

  localparam logic CSB_IDLE   = 1'b0;
  localparam logic WEB_IDLE   = 1'b1;
  localparam logic OEB_IDLE   = 1'b1;
  localparam logic OEB_ACTIVE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HASH = 3'd1,
    ST_SET_ADDR  = 3'd2,
    ST_READ      = 3'd3,
    ST_CHECK     = 3'd4,
    ST_EMIT      = 3'd5,
    ST_DONE      = 3'd6
  } kq_state_e;

endpackage

// File: rtl/kmer_bit_check.sv
// Registers the two SRAM rows at the end of the read cycle, then registers the AND of
// the two selected bits as the solid flag on the following cycle.
module kmer_bit_check #(
  parameter int ROW_W = 32,
  parameter int BIT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             check,
  input  logic [ROW_W-1:0] dout1,
  input  logic [ROW_W-1:0] dout2,
  input  logic [BIT_W-1:0] bit1,
  input  logic [BIT_W-1:0] bit2,
  output logic             solid
);

  logic [ROW_W-1:0] row1_q;
  logic [ROW_W-1:0] row2_q;

  // NOTE: non-blocking assignments so the check stage reads the rows captured on a
  // previous edge, never the value being written on this one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row1_q <= '0;
      row2_q <= '0;
      solid  <= 1'b0;
    end else begin
      if (capture) begin
        row1_q <= dout1;
        row2_q <= dout2;
      end
      if (check) begin
        solid <= row1_q[bit1] & row2_q[bit2];
      end
    end
  end

endmodule

// File: rtl/kmer_query_controller.sv
// K-mer query controller: accepts hashed addresses, reads two SRAM rows, emits a solid flag
// per k-mer and keeps pass counts. Define KMER_QUERY_STATS_EN for weak-k-mer statistics.
module kmer_query_controller
  import dna_ec_pkg::*;
#(
  parameter int NUM_KMERS = NUM_KMERS_DEFAULT,
  parameter int ROW_AW    = 8,
  parameter int ROW_W     = 32,
  localparam int BIT_W    = $clog2(ROW_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_query,
  input  logic                    hash_valid,
  output logic                    hash_ready,
  input  logic [ROW_AW+BIT_W-1:0] hash1,
  input  logic [ROW_AW+BIT_W-1:0] hash2,
  output logic [ROW_AW-1:0]       A1,
  output logic [ROW_AW-1:0]       A2,
  output logic                    CSB1,
  output logic                    CSB2,
  output logic                    WEB1,
  output logic                    WEB2,
  output logic                    OEB1,
  output logic                    OEB2,
  input  logic [ROW_W-1:0]        DOUT1,
  input  logic [ROW_W-1:0]        DOUT2,
  output logic                    kmer_valid,
  input  logic                    kmer_ready,
  output logic                    kmer_solid,
  output logic [7:0]              kmer_idx,
  output logic [7:0]              solid_count,
  output logic                    query_done,
  output logic [7:0]              weak_count,
  output logic [7:0]              first_weak_idx
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_KMERS - 1);

  kq_state_e state_q;
  kq_state_e state_d;

  logic [ROW_AW+BIT_W-1:0] hash1_q;
  logic [ROW_AW+BIT_W-1:0] hash2_q;

  logic start_accept;
  logic hash_accept;
  logic emit_hs;
  logic sram_read;

  assign start_accept = (state_q == ST_IDLE) && start_query;
  assign hash_accept  = (state_q == ST_WAIT_HASH) && hash_valid;
  assign emit_hs      = (state_q == ST_EMIT) && kmer_ready;
  assign sram_read    = (state_q == ST_SET_ADDR) || (state_q == ST_READ);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (start_query) state_d = ST_WAIT_HASH;
      ST_WAIT_HASH: if (hash_valid)  state_d = ST_SET_ADDR;
      ST_SET_ADDR:  state_d = ST_READ;
      ST_READ:      state_d = ST_CHECK;
      ST_CHECK:     state_d = ST_EMIT;
      ST_EMIT:      if (kmer_ready) state_d = (kmer_idx == LAST_IDX) ? ST_DONE : ST_WAIT_HASH;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hash1_q <= '0;
      hash2_q <= '0;
    end else if (hash_accept) begin
      hash1_q <= hash1;
      hash2_q <= hash2;
    end
  end

  // Rows stay on the address bus between reads; only OEB marks an actual access.
  assign A1   = hash1_q[ROW_AW+BIT_W-1:BIT_W];
  assign A2   = hash2_q[ROW_AW+BIT_W-1:BIT_W];
  assign CSB1 = CSB_IDLE;
  assign CSB2 = CSB_IDLE;
  assign WEB1 = WEB_IDLE;
  assign WEB2 = WEB_IDLE;
  assign OEB1 = sram_read ? OEB_ACTIVE : OEB_IDLE;
  assign OEB2 = sram_read ? OEB_ACTIVE : OEB_IDLE;

  assign hash_ready = (state_q == ST_WAIT_HASH);
  assign kmer_valid = (state_q == ST_EMIT);
  assign query_done = (state_q == ST_DONE);

  kmer_bit_check #(
    .ROW_W (ROW_W),
    .BIT_W (BIT_W)
  ) u_bit_check (
    .clk     (clk),
    .reset   (reset),
    .capture (state_q == ST_READ),
    .check   (state_q == ST_CHECK),
    .dout1   (DOUT1),
    .dout2   (DOUT2),
    .bit1    (hash1_q[BIT_W-1:0]),
    .bit2    (hash2_q[BIT_W-1:0]),
    .solid   (kmer_solid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kmer_idx    <= '0;
      solid_count <= '0;
    end else if (start_accept) begin
      kmer_idx    <= '0;
      solid_count <= '0;
    end else if (emit_hs) begin
      kmer_idx <= kmer_idx + 8'd1;
      if (kmer_solid) solid_count <= solid_count + 8'd1;
    end
  end

`ifdef KMER_QUERY_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weak_count     <= '0;
      first_weak_idx <= 8'hFF;
    end else if (start_accept) begin
      weak_count     <= '0;
      first_weak_idx <= 8'hFF;
    end else if (emit_hs && !kmer_solid) begin
      weak_count <= weak_count + 8'd1;
      if (first_weak_idx == 8'hFF) first_weak_idx <= kmer_idx;
    end
  end
`else
  assign weak_count     = 8'h00;
  assign first_weak_idx = 8'hFF;
`endif

endmodule

// File: tb/tb_kmer_query_controller.sv
// Self-checking bench for kmer_query_controller: a single-k-mer instance and a default
// instance, both fed from bench SRAM arrays, checked against a k-mer-level reference model.
`timescale 1ns/1ps
module tb_kmer_query_controller;

  localparam int HW = 13;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];

  // Default-size instance
  logic          f_start = 1'b0, f_hash_valid = 1'b0, f_kmer_ready = 1'b0;
  logic [HW-1:0] f_hash1 = '0, f_hash2 = '0;
  logic          f_hash_ready, f_csb1, f_csb2, f_web1, f_web2, f_oeb1, f_oeb2;
  logic [7:0]    f_a1, f_a2, f_kmer_idx, f_solid_count, f_weak_count, f_first_weak_idx;
  logic [31:0]   f_dout1, f_dout2;
  logic          f_kmer_valid, f_kmer_solid, f_query_done;

  // Single-k-mer instance
  logic          o_start = 1'b0, o_hash_valid = 1'b0, o_kmer_ready = 1'b0;
  logic [HW-1:0] o_hash1 = '0, o_hash2 = '0;
  logic          o_hash_ready, o_csb1, o_csb2, o_web1, o_web2, o_oeb1, o_oeb2;
  logic [7:0]    o_a1, o_a2, o_kmer_idx, o_solid_count, o_weak_count, o_first_weak_idx;
  logic [31:0]   o_dout1, o_dout2;
  logic          o_kmer_valid, o_kmer_solid, o_query_done;

  kmer_query_controller u_full (
    .clk(clk), .reset(reset), .start_query(f_start),
    .hash_valid(f_hash_valid), .hash_ready(f_hash_ready),
    .hash1(f_hash1), .hash2(f_hash2), .A1(f_a1), .A2(f_a2),
    .CSB1(f_csb1), .CSB2(f_csb2), .WEB1(f_web1), .WEB2(f_web2), .OEB1(f_oeb1), .OEB2(f_oeb2),
    .DOUT1(f_dout1), .DOUT2(f_dout2),
    .kmer_valid(f_kmer_valid), .kmer_ready(f_kmer_ready), .kmer_solid(f_kmer_solid),
    .kmer_idx(f_kmer_idx), .solid_count(f_solid_count), .query_done(f_query_done),
    .weak_count(f_weak_count), .first_weak_idx(f_first_weak_idx)
  );

  kmer_query_controller #(.NUM_KMERS(1)) u_one (
    .clk(clk), .reset(reset), .start_query(o_start),
    .hash_valid(o_hash_valid), .hash_ready(o_hash_ready),
    .hash1(o_hash1), .hash2(o_hash2), .A1(o_a1), .A2(o_a2),
    .CSB1(o_csb1), .CSB2(o_csb2), .WEB1(o_web1), .WEB2(o_web2), .OEB1(o_oeb1), .OEB2(o_oeb2),
    .DOUT1(o_dout1), .DOUT2(o_dout2),
    .kmer_valid(o_kmer_valid), .kmer_ready(o_kmer_ready), .kmer_solid(o_kmer_solid),
    .kmer_idx(o_kmer_idx), .solid_count(o_solid_count), .query_done(o_query_done),
    .weak_count(o_weak_count), .first_weak_idx(o_first_weak_idx)
  );

  // Synchronous-read SRAM models
  always @(posedge clk) begin
    if (!f_csb1 && !f_oeb1) f_dout1 <= mem1[f_a1];
    if (!f_csb2 && !f_oeb2) f_dout2 <= mem2[f_a2];
    if (!o_csb1 && !o_oeb1) o_dout1 <= mem1[o_a1];
    if (!o_csb2 && !o_oeb2) o_dout2 <= mem2[o_a2];
  end

  int done_cnt = 0;
  always @(posedge clk) if (f_query_done) done_cnt++;

  int checks = 0;
  int errors = 0;

  // Reference model state for the current pass of the default instance
  int m_solid, m_weak, m_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_clear();
    m_solid = 0;
    m_weak  = 0;
    m_first = 255;
  endtask

  task automatic check_stats(input string tag);
`ifdef KMER_QUERY_STATS_EN
    check({tag, "_weak_count"}, f_weak_count, m_weak);
    check({tag, "_first_weak"}, f_first_weak_idx, m_first);
`else
    check({tag, "_weak_tie"}, f_weak_count, 8'h00);
    check({tag, "_first_tie"}, f_first_weak_idx, 8'hFF);
`endif
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hash_ready"}, f_hash_ready, 1'b0);
    check({tag, "_kmer_valid"}, f_kmer_valid, 1'b0);
    check({tag, "_kmer_solid"}, f_kmer_solid, 1'b0);
    check({tag, "_query_done"}, f_query_done, 1'b0);
    check({tag, "_a1"}, f_a1, 8'h00);
    check({tag, "_a2"}, f_a2, 8'h00);
    check({tag, "_csb"}, {f_csb1, f_csb2}, 2'b00);
    check({tag, "_web"}, {f_web1, f_web2}, 2'b11);
    check({tag, "_oeb"}, {f_oeb1, f_oeb2}, 2'b11);
    check({tag, "_kmer_idx"}, f_kmer_idx, 8'h00);
    check({tag, "_solid_count"}, f_solid_count, 8'h00);
    model_clear();
    check_stats(tag);
  endtask

  // One k-mer on the default instance. mode: 0 random memory, 1 force solid, 2 force weak.
  task automatic f_kmer(input int k, input int mode, input int bp);
    logic [7:0] r1, r2;
    logic [4:0] b1, b2;
    logic       want;
    int         n;
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    b1 = 5'($urandom_range(0, 31));
    b2 = 5'($urandom_range(0, 31));
    if (mode != 0) begin
      mem1[r1][b1] = 1'b1;
      mem2[r2][b2] = (mode == 1);
    end
    want = mem1[r1][b1] & mem2[r2][b2];

    f_hash1 = {r1, b1};
    f_hash2 = {r2, b2};
    f_hash_valid = 1'b1;
    n = 0;
    while (!f_hash_ready && n < 20) begin tick(); n++; end
    check("hash_ready_wait", n, 0);
    tick();
    f_hash_valid = 1'b0;
    check("set_addr_a1", f_a1, r1);
    check("set_addr_a2", f_a2, r2);
    check("set_addr_oeb", {f_oeb1, f_oeb2}, 2'b00);
    n = 1;
    while (!f_kmer_valid && n < 20) begin tick(); n++; end
    check("latency", n, 4);
    check("kmer_solid", f_kmer_solid, want);
    check("kmer_idx", f_kmer_idx, k);

    for (int i = 0; i < bp; i++) begin
      tick();
      check("bp_valid", f_kmer_valid, 1'b1);
      check("bp_solid", f_kmer_solid, want);
      check("bp_idx", f_kmer_idx, k);
      check("bp_hash_ready", f_hash_ready, 1'b0);
      check("bp_oeb", {f_oeb1, f_oeb2}, 2'b11);
    end

    f_kmer_ready = 1'b1;
    tick();
    f_kmer_ready = 1'b0;
    m_solid += int'(want);
    if (!want) begin
      m_weak++;
      if (m_first == 255) m_first = k;
    end
    check("solid_count", f_solid_count, m_solid);
    check("valid_drop", f_kmer_valid, 1'b0);
    check_stats("kmer");
  endtask

  // Stall in WAIT_HASH with a stray start pulse that must be ignored
  task automatic f_stall(input int k);
    for (int i = 0; i < 10; i++) begin
      f_start = (i == 5);
      tick();
      check("stall_hash_ready", f_hash_ready, 1'b1);
      check("stall_web", {f_web1, f_web2}, 2'b11);
      check("stall_oeb", {f_oeb1, f_oeb2}, 2'b11);
      check("stall_valid", f_kmer_valid, 1'b0);
      check("stall_idx", f_kmer_idx, k);
      check("stall_solid_count", f_solid_count, m_solid);
    end
    f_start = 1'b0;
  endtask

  // One pass of the single-k-mer instance with the fixed hashes
  task automatic o_pass(input logic want);
    o_start = 1'b1;
    tick();
    o_start = 1'b0;
    check("one_start_idx", o_kmer_idx, 8'd0);
    check("one_start_count", o_solid_count, 8'd0);
    check("one_hash_ready", o_hash_ready, 1'b1);
    o_hash1 = {8'h05, 5'd3};
    o_hash2 = {8'h0A, 5'd17};
    o_hash_valid = 1'b1;
    tick();
    o_hash_valid = 1'b0;
    check("one_a1", o_a1, 8'd5);
    check("one_a2", o_a2, 8'd10);
    check("one_csb", {o_csb1, o_csb2}, 2'b00);
    check("one_oeb_set", {o_oeb1, o_oeb2}, 2'b00);
    check("one_web", {o_web1, o_web2}, 2'b11);
    tick();
    check("one_oeb_read", {o_oeb1, o_oeb2}, 2'b00);
    tick();
    check("one_check_valid", o_kmer_valid, 1'b0);
    tick();
    check("one_emit_valid", o_kmer_valid, 1'b1);
    check("one_solid", o_kmer_solid, want);
    check("one_idx", o_kmer_idx, 8'd0);
    o_kmer_ready = 1'b1;
    tick();
    o_kmer_ready = 1'b0;
    check("one_done", o_query_done, 1'b1);
    check("one_solid_count", o_solid_count, want ? 8'd1 : 8'd0);
    check("one_valid_done", o_kmer_valid, 1'b0);
`ifdef KMER_QUERY_STATS_EN
    check("one_weak_count", o_weak_count, want ? 8'd0 : 8'd1);
    check("one_first_weak", o_first_weak_idx, want ? 8'hFF : 8'h00);
`else
    check("one_weak_tie", o_weak_count, 8'h00);
    check("one_first_tie", o_first_weak_idx, 8'hFF);
`endif
    tick();
    check("one_done_drop", o_query_done, 1'b0);
    check("one_idle_ready", o_hash_ready, 1'b0);
    check("one_count_held", o_solid_count, want ? 8'd1 : 8'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = $urandom;
      mem2[i] = $urandom;
    end

    // Reset state
    repeat (3) tick();
    check_reset_values("reset");
    check("one_reset_oeb", {o_oeb1, o_oeb2}, 2'b11);
    check("one_reset_ready", o_hash_ready, 1'b0);
    reset = 1'b1;
    tick();

    // Single solid, then single weak k-mer
    mem1[5][3]   = 1'b1;
    mem2[10][17] = 1'b1;
    o_pass(1'b1);
    mem2[10][17] = 1'b0;
    o_pass(1'b0);

    // Full pass, every 4th solid, with a stall and a 5-cycle backpressure
    f_start = 1'b1;
    tick();
    f_start = 1'b0;
    model_clear();
    check("passA_idx", f_kmer_idx, 8'd0);
    check("passA_hash_ready", f_hash_ready, 1'b1);
    for (int k = 0; k < 212; k++) begin
      if (k == 3) f_stall(k);
      f_kmer(k, (k % 4 == 0) ? 1 : 2, (k == 7) ? 5 : int'($urandom_range(0, 1)));
    end
    check("passA_done", f_query_done, 1'b1);
    check("passA_solid_53", f_solid_count, 8'd53);
    tick();
    check("passA_done_drop", f_query_done, 1'b0);
    check("passA_idle_ready", f_hash_ready, 1'b0);
    repeat (3) tick();
    check("passA_count_held", f_solid_count, 8'd53);
    check("passA_done_once", done_cnt, 1);

    // Second pass aborted by reset at k-mer 100
    f_start = 1'b1;
    tick();
    f_start = 1'b0;
    model_clear();
    check("passB_idx_wrap", f_kmer_idx, 8'd0);
    check("passB_count_clear", f_solid_count, 8'd0);
    for (int k = 0; k < 100; k++) f_kmer(k, 0, int'($urandom_range(0, 1)));
    f_hash_valid = 1'b1;
    tick();
    f_hash_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("midreset_stays_idle", f_hash_ready, 1'b0);
    check("midreset_no_done", done_cnt, 1);

    // Fresh pass with random memory contents
    f_start = 1'b1;
    tick();
    f_start = 1'b0;
    model_clear();
    check("passC_count_clear", f_solid_count, 8'd0);
    for (int k = 0; k < 212; k++) f_kmer(k, 0, int'($urandom_range(0, 2)));
    check("passC_done", f_query_done, 1'b1);
    check("passC_solid", f_solid_count, m_solid);
    tick();
    check("passC_done_total", done_cnt, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
